// File: rtl/uart_peripheral_if.sv
// rtl/uart_peripheral_if.sv - register bus between CPU and UART peripheral
interface uart_peripheral_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, wr, addr, wdata, input rdata);
  modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_peripheral.sv
// rtl/uart_peripheral.sv - memory-mapped 8N1 UART, full duplex, single-byte TX and RX buffers
module uart_peripheral #(
  parameter int BAUD_DIV = 5208
) (
  input  logic               clk,
  input  logic               reset,
  uart_peripheral_if.slave   bus,
  input  logic               rxd,
  output logic               txd,
  output logic               irqout
);

  localparam logic [31:0] ADDR_TX  = 32'h4000_0018;
  localparam logic [31:0] ADDR_RX  = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;
  localparam logic [15:0] DIV_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      tx_state, rx_state;
  logic [15:0] tx_cnt, rx_cnt;
  logic [2:0]  tx_bit, rx_bit;
  logic [7:0]  tx_data, tx_shift, rx_shift, rx_data;
  logic        tx_busy, tx_done, rx_valid, frame_err, overrun;
  logic        tx_irq_en, rx_irq_en;
  logic        rx_s1, rx_s2, rx_prev;
  logic        tx_wr, con_wr, rx_rd, con_rd;
  logic [31:0] con_val;
  logic        unused_wdata;

  assign tx_wr  = bus.wr & (bus.addr == ADDR_TX);
  assign con_wr = bus.wr & (bus.addr == ADDR_CON);
  assign rx_rd  = bus.rd & (bus.addr == ADDR_RX);
  assign con_rd = bus.rd & (bus.addr == ADDR_CON);
  assign unused_wdata = ^bus.wdata[31:8];

  assign con_val = {25'b0, overrun, frame_err, tx_busy, rx_valid, tx_done, rx_irq_en, tx_irq_en};
  assign irqout  = (tx_irq_en & tx_done) | (rx_irq_en & rx_valid);

  always_comb begin
    bus.rdata = 32'b0;
    if (bus.rd) begin
      case (bus.addr)
        ADDR_TX:  bus.rdata = {24'b0, tx_data};
        ADDR_RX:  bus.rdata = {24'b0, rx_data};
        ADDR_CON: bus.rdata = con_val;
        default:  bus.rdata = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_irq_en <= 1'b0;
      rx_irq_en <= 1'b0;
    end else if (con_wr) begin
      tx_irq_en <= bus.wdata[0];
      rx_irq_en <= bus.wdata[1];
    end
  end

  // Transmitter: tx_data holds the byte for read-back, tx_shift is consumed by the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_data  <= 8'h00;
      tx_shift <= 8'h00;
      tx_cnt   <= 16'h0;
      tx_bit   <= 3'd0;
    end else begin
      if (con_rd) tx_done <= 1'b0;
      case (tx_state)
        S_IDLE: begin
          if (tx_wr) begin
            tx_data  <= bus.wdata[7:0];
            tx_shift <= bus.wdata[7:0];
            tx_busy  <= 1'b1;
            txd      <= 1'b0;
            tx_cnt   <= 16'h0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt   <= 16'h0;
            tx_bit   <= 3'd0;
            txd      <= tx_shift[0];
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 16'h1;
          end
        end
        S_DATA: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= 16'h0;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_shift <= {1'b0, tx_shift[7:1]};
              txd      <= tx_shift[1];
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'h1;
          end
        end
        S_STOP: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt   <= 16'h0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
            tx_state <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 16'h1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // Receiver: flag sets are written after the read-clears so a same-edge set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= S_IDLE;
      rx_cnt    <= 16'h0;
      rx_bit    <= 3'd0;
      rx_shift  <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (rx_rd) rx_valid <= 1'b0;
      if (con_rd) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= 16'h0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= 16'h0;
            rx_bit   <= 3'd0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'h1;
          end
        end
        S_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= 16'h0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'h1;
          end
        end
        S_STOP: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= 16'h0;
            rx_state <= S_IDLE;
            if (rx_s2) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              if (rx_valid && !rx_rd) overrun <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'h1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_peripheral.sv
// tb/tb_uart_peripheral.sv - directed self-checking bench for uart_peripheral at BAUD_DIV=16
module tb_uart_peripheral;

  localparam int BAUD = 16;
  localparam logic [31:0] A_TX  = 32'h4000_0018;
  localparam logic [31:0] A_RX  = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic txd, irqout;
  int   n_checks = 0;
  int   n_fail = 0;

  uart_peripheral_if bus();

  uart_peripheral #(.BAUD_DIV(BAUD)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .rxd    (rxd),
    .txd    (txd),
    .irqout (irqout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    tick(1);
    bus.wr = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus.rd = 1'b1; bus.addr = a;
    #1 d = bus.rdata;
    tick(1);
    bus.rd = 1'b0;
    check(name, d, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(BAUD);
    end
    rxd = stop;
    tick(BAUD);
    rxd = 1'b1;
    tick(BAUD);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;

    vecs[0]  = '{1'b1, 1'b0, A_CON,         32'h0,         32'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, A_TX,          32'h0,         32'h0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, A_RX,          32'h0,         32'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, A_CON,         32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, A_CON,         32'h0,         32'h3, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h4000_0024, 32'h0,         32'h0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, A_CON,         32'h0,         32'h0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, A_CON,         32'h0000_0002, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, A_CON,         32'h0,         32'h2, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, A_CON,         32'h0,         32'h0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, A_CON,         32'h0,         32'h0, 1'b0};

    tick(3);
    check("reset txd", txd, 1);
    check("reset irqout", irqout, 0);
    reset = 1'b0;
    tick(1);

    for (int i = 0; i < 11; i++) begin
      bus.rd = vecs[i].rd; bus.wr = vecs[i].wr;
      bus.addr = vecs[i].addr; bus.wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d rdata", i), bus.rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d irqout", i), irqout, vecs[i].exp_irq);
      tick(1);
    end
    bus.rd = 1'b0; bus.wr = 1'b0;

    // Transmit 0x41 with tx_irq_en set; a second write mid-frame must be ignored.
    bus_write(A_CON, 32'h1);
    bus_write(A_TX, 32'h41);
    frame = {1'b1, 8'h41, 1'b0};
    for (int c = 0; c < 10 * BAUD; c++) begin
      bus.wr = (c == 37);
      bus.rd = (c % BAUD == 8);
      bus.addr = (c == 37) ? A_TX : A_CON;
      bus.wdata = 32'h55;
      #1;
      check($sformatf("txd cycle %0d", c), txd, frame[c / BAUD]);
      if (c % BAUD == 8) check($sformatf("tx busy con cycle %0d", c), bus.rdata, 32'h11);
      tick(1);
    end
    bus.wr = 1'b0; bus.rd = 1'b0;
    check("txd idle after frame", txd, 1);
    check("tx_done irqout", irqout, 1);
    read_check("con tx_done", A_CON, 32'h05);
    check("irqout after con read", irqout, 0);
    read_check("tx_data readback", A_TX, 32'h41);
    read_check("con tx_done cleared", A_CON, 32'h01);

    // Good receive with rx_irq_en.
    bus_write(A_CON, 32'h2);
    send_rx(8'hA5, 1'b1);
    check("rx irqout set", irqout, 1);
    read_check("con rx_valid", A_CON, 32'h0A);
    read_check("rx_data A5", A_RX, 32'hA5);
    check("rx irqout cleared", irqout, 0);
    read_check("con rx_valid cleared", A_CON, 32'h02);

    // False start: 5-cycle glitch.
    rxd = 1'b0; tick(5); rxd = 1'b1; tick(40);
    read_check("con after false start", A_CON, 32'h02);
    read_check("rx_data after false start", A_RX, 32'hA5);

    // Frame with stop bit 0.
    send_rx(8'h3C, 1'b0);
    read_check("con frame_err", A_CON, 32'h22);
    read_check("con frame_err cleared", A_CON, 32'h02);
    read_check("rx_data after frame_err", A_RX, 32'hA5);

    // Overrun: two frames with no read between.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    check("overrun irqout", irqout, 1);
    read_check("con overrun", A_CON, 32'h4A);
    read_check("con overrun cleared", A_CON, 32'h0A);
    read_check("rx_data 22", A_RX, 32'h22);
    read_check("con after rx read", A_CON, 32'h02);

    // Reset during data bit 3 (frame bit 4) of a transmit.
    bus_write(A_CON, 32'h3);
    bus_write(A_TX, 32'h41);
    tick(4 * BAUD + 5);
    check("txd low before reset", txd, 0);
    #2 reset = 1'b1;
    #1;
    check("txd async reset", txd, 1);
    check("irqout async reset", irqout, 0);
    tick(2);
    reset = 1'b0;
    read_check("con after reset", A_CON, 32'h0);
    read_check("tx_data after reset", A_TX, 32'h0);
    read_check("rx_data after reset", A_RX, 32'h0);
    tick(12 * BAUD);
    check("txd idle after reset", txd, 1);
    read_check("con no flags after reset", A_CON, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_peripheral.md
UART_PERIPHERAL -- requirements
Module: uart_peripheral

Interface
REQ-001 Parameter BAUD_DIV, default 5208, SHALL set the clock cycles per serial bit; legal range 4..65535.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rd  input  1  bus read strobe.
REQ-005 wr  input  1  bus write strobe.
REQ-006 addr  input  32  bus byte address.
REQ-007 wdata  input  32  bus write data.
REQ-008 rdata  output  32  bus read data, combinational.
REQ-009 rxd  input  1  serial receive line, asynchronous, idle high.
REQ-010 txd  output  1  serial transmit line, idle high.
REQ-011 irqout  output  1  level interrupt request to CPU.

Function
REQ-012 Register map SHALL be: 0x40000018 TX_DATA (W: byte wdata[7:0]; R: last written byte); 0x4000001C RX_DATA (R: {24'b0, byte}); 0x40000020 UART_CON (R/W).
REQ-013 UART_CON bits SHALL be: [0] tx_irq_en RW, [1] rx_irq_en RW, [2] tx_done RO, [3] rx_valid RO, [4] tx_busy RO, [5] frame_err RO, [6] overrun RO, [31:7] read zero; a write updates only bits [1:0].
REQ-014 rdata SHALL be the addressed register when rd=1 and addr matches, else 32'b0; no bus wait states.
REQ-015 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly BAUD_DIV cycles.
REQ-016 TX FSM states: IDLE, START, DATA, STOP; a write to TX_DATA in IDLE latches the byte, sets tx_busy and drives txd low from the next rising edge.
REQ-017 A TX_DATA write while tx_busy=1 SHALL be ignored (no queue, byte and frame unchanged).
REQ-018 At end of the stop bit (10*BAUD_DIV cycles after start) TX SHALL return to IDLE, clear tx_busy and set tx_done.
REQ-019 tx_done SHALL clear on the clock edge of a read of UART_CON; a simultaneous set wins.
REQ-020 rxd SHALL pass a 2-flop synchronizer; RX logic uses only the synchronized value.
REQ-021 RX FSM states: IDLE, START, DATA, STOP; a synchronized 1->0 edge in IDLE enters START.
REQ-022 In START, after BAUD_DIV/2 (integer) cycles the line SHALL be resampled; high -> false start, return to IDLE with no flag change; low -> DATA.
REQ-023 Data bits and stop bit SHALL be sampled every BAUD_DIV cycles from the mid-start point.
REQ-024 Stop sample 1: RX_DATA <= shifted byte, rx_valid <= 1; stop sample 0: byte discarded, frame_err <= 1; both return to IDLE.
REQ-025 If a good byte completes while rx_valid=1 and no RX_DATA read occurs that cycle, RX_DATA SHALL be overwritten and overrun set.
REQ-026 A read of RX_DATA SHALL clear rx_valid on that edge; if a good byte completes on the same edge, new byte loads, rx_valid stays 1, overrun unchanged.
REQ-027 frame_err and overrun SHALL clear on the clock edge of a read of UART_CON.
REQ-028 irqout SHALL equal (tx_irq_en & tx_done) | (rx_irq_en & rx_valid).
REQ-029 TX and RX SHALL operate independently and concurrently (full duplex).

Reset
REQ-030 Reset SHALL force txd=1, both FSMs to IDLE, all UART_CON bits, TX_DATA, RX_DATA, counters and synchronizer to 0 (synchronizer to 1), irqout=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; txd returns to 1 asynchronously, no flag set on release.

Verification (BAUD_DIV=16)
REQ-032 Write 0x41 to 0x40000018 -> txd 0,1,0,0,0,0,0,1,0,1 each held 16 cycles; tx_busy=1 throughout, tx_done=1 at cycle 160.
REQ-033 Write 0x55 during that frame -> ignored; txd still sends 0x41; read TX_DATA=0x41.
REQ-034 Drive rxd with 0xA5 frame, rx_irq_en=1 -> rx_valid=1, irqout=1; read 0x4000001C returns 0x000000A5, next cycle rx_valid=0, irqout=0.
REQ-035 rxd low pulse of 5 cycles -> false start; no flags, RX_DATA unchanged; frame with stop bit 0 -> frame_err=1, rx_valid=0.
REQ-036 Two frames 0x11, 0x22 without reading -> RX_DATA=0x22, overrun=1; UART_CON read clears overrun.
REQ-037 Assert reset at bit 4 of TX frame -> txd=1 immediately, UART_CON reads 0 after release.
